cdc_event_tx: RTL
=================

CDC_EVENT_TX -- requirements
Module: cdc_event_tx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the event payload width in bits.
REQ-002 The module SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the number of synchronizer flip flops on tx_ack.
REQ-003 The module SHALL have port clock, input, 1 bit: 50 MHz system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_s2_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port event_valid, input, 1 bit: a payload is offered in this cycle.
REQ-006 The module SHALL have port event_data, input, DATA_WIDTH bits: the payload sampled on acceptance.
REQ-007 The module SHALL have port event_ready, output, 1 bit: high when an offered payload is accepted this cycle.
REQ-008 The module SHALL have port tx_req, output, 1 bit: registered 4-phase request to the receiving clock domain.
REQ-009 The module SHALL have port tx_data, output, DATA_WIDTH bits: registered payload to the receiving domain.
REQ-010 The module SHALL have port tx_ack, input, 1 bit: acknowledge from the receiving domain, asynchronous to clock.
REQ-011 The module SHALL have port done, output, 1 bit: single-cycle pulse on handshake completion.
REQ-012 The module SHALL have port drop_count, output, 8 bits: saturating count of offered but unaccepted events.

Function
REQ-013 The module SHALL synchronize tx_ack through SYNC_STAGES flip flops to ack_s; no logic other than the first stage SHALL sample tx_ack.
REQ-014 The module SHALL implement a state machine with states IDLE, REQ_HIGH and REQ_LOW.
REQ-015 event_ready SHALL be combinationally high only when state = IDLE and ack_s = 0.
REQ-016 Acceptance: when event_valid = 1 and event_ready = 1 at edge N, the module SHALL register tx_data = event_data and tx_req = 1, and enter REQ_HIGH; both SHALL be visible after edge N.
REQ-017 In REQ_HIGH, on the first edge with ack_s = 1, the module SHALL set tx_req = 0 and enter REQ_LOW.
REQ-018 In REQ_LOW, on the first edge with ack_s = 0, the module SHALL enter IDLE and assert done for exactly the following cycle.
REQ-019 tx_data SHALL remain stable from acceptance until the module returns to IDLE; it SHALL hold its last value while in IDLE.
REQ-020 tx_req SHALL change only from IDLE to REQ_HIGH (rising) and from REQ_HIGH to REQ_LOW (falling); it SHALL never toggle within a state.
REQ-021 An offered event (event_valid = 1) with event_ready = 0 SHALL be discarded and SHALL increment drop_count by 1, saturating at 255 with no wrap.
REQ-022 The module SHALL NOT accept an event in the same cycle it transitions from REQ_LOW to IDLE; the earliest acceptance is the next edge.
REQ-023 If ack_s = 1 while in IDLE (protocol error), the module SHALL stay in IDLE with event_ready = 0 until ack_s = 0.
REQ-024 Minimum handshake period SHALL be 2*SYNC_STAGES + 3 cycles for an immediately responding receiver.

Reset
REQ-025 While reset_s2_n = 0, the module SHALL asynchronously force state = IDLE, tx_req = 0, tx_data = 0, done = 0, drop_count = 0, and all sync flops = 0.
REQ-026 A reset asserted mid-handshake SHALL drop tx_req immediately, without waiting for a clock edge; after release, the module SHALL honour REQ-023 if tx_ack is still high.
REQ-027 The first acceptance after reset release SHALL occur no earlier than the first rising edge with reset_s2_n = 1.

Verification
REQ-028 Single event: event_data = 0xA5 pulse, with the receiver acking 3 cycles after tx_req and releasing 3 cycles after tx_req falls -> tx_data = 0xA5 stable throughout, one done pulse, drop_count = 0.
REQ-029 Back-to-back: event_valid held high with 0x01, 0x02 and 0x03 presented on consecutive accept cycles -> three handshakes in order, with tx_req low for at least one cycle between them.
REQ-030 Overflow: 300 event_valid cycles while stuck in REQ_HIGH (tx_ack = 0) -> drop_count = 255, state unchanged, tx_req = 1.
REQ-031 Mid-handshake reset: reset_s2_n pulsed low in REQ_LOW -> tx_req, tx_data and drop_count read 0 asynchronously, and no done pulse occurs.
REQ-032 Stuck ack: tx_ack = 1 at reset release -> event_ready = 0 and event_valid is counted as dropped; after tx_ack = 0 plus SYNC_STAGES cycles -> event_ready = 1.
REQ-033 Synchronizer: tx_ack changed asynchronously (random phase) -> the state change occurs exactly SYNC_STAGES to SYNC_STAGES+1 cycles later.

Source files
------------

// File: rtl/cdc_event_tx.sv
// Sends payloads across a clock boundary with a 4-phase req/ack handshake. tx_req/tx_data register on the accept edge.
// One event is in flight at a time. event_ready is low outside IDLE or while the synchronized ack is high. Events refused then are counted in drop_count.
module cdc_event_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_s2_n,
    input  logic                  event_valid,
    input  logic [DATA_WIDTH-1:0] event_data,
    output logic                  event_ready,
    output logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ack,
    output logic                  done,
    output logic [7:0]            drop_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HIGH = 2'd1,
        REQ_LOW  = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    tx_req_q;
    logic [DATA_WIDTH-1:0]   tx_data_q;
    logic                    done_q;
    logic [7:0]              drop_q;
    logic [7:0]              drop_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    ack_s;

    // Only sync_q[0] ever samples the asynchronous tx_ack.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tx_ack};
        end
    end

    assign ack_s       = sync_q[SYNC_STAGES-1];
    assign event_ready = (state_q == IDLE) && !ack_s;

    always_comb begin
        drop_d = drop_q;
        if (event_valid && !event_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // A stale ack left high in IDLE holds event_ready low until it clears.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state_q   <= IDLE;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (event_valid && event_ready) begin
                        tx_data_q <= event_data;
                        tx_req_q  <= 1'b1;
                        state_q   <= REQ_HIGH;
                    end
                end
                REQ_HIGH: begin
                    if (ack_s) begin
                        tx_req_q <= 1'b0;
                        state_q  <= REQ_LOW;
                    end
                end
                REQ_LOW: begin
                    if (!ack_s) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_req_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_data    = tx_data_q;
    assign done       = done_q;
    assign drop_count = drop_q;

endmodule
